// File: rtl/krz_pkg.sv
// rtl/krz_pkg.sv - shared constants and types for the Kronos fetch path
package krz_pkg;

    localparam logic [31:0] KRZ_BOOTROM_BASE  = 32'h0000_0000;
    localparam int          KRZ_BOOTROM_DEPTH = 1024;

    // All-zero word decodes as an illegal instruction, so the core traps on it
    localparam logic [31:0] INSTR_ILLEGAL = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/krz_fetch_responder.sv
// rtl/krz_fetch_responder.sv - boot-memory responder for the core instruction-fetch port
module krz_fetch_responder
    import krz_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = KRZ_BOOTROM_BASE,
    parameter int          DEPTH       = KRZ_BOOTROM_DEPTH,
    parameter int          WAIT_STATES = 0,
    parameter int          AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic [31:0]   instr_addr,
    input  logic          instr_req,
    output logic [31:0]   instr_data,
    output logic          instr_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_en,
    input  logic [31:0]   mem_rdata,
    output logic          fault,
    output logic [31:0]   fault_addr,
    output logic [31:0]   fetch_count
);

    // Window size in bytes; one extra bit so a large DEPTH cannot overflow the compare
    localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH) << 2;
    localparam logic [3:0]  WAIT_LOAD    = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    fetch_state_e state_q, state_d;
    logic [3:0]   wait_q, wait_d;
    logic [31:0]  fault_addr_q;
    logic [31:0]  fetch_count_q;

    logic [31:0]   offset;
    logic          in_window;
    logic          aligned;
    logic          hit;
    logic [AW-1:0] word_addr;
    logic          count_inc;
    logic          fault_capture;

    // Address decode against the boot-memory window
    always_comb begin
        offset    = instr_addr - BASE_ADDR;
        in_window = ({1'b0, offset} < WINDOW_BYTES);
        aligned   = (instr_addr[1:0] == 2'b00);
        hit       = in_window & aligned;
        word_addr = offset[AW+1:2];
    end

    // Next-state and output decode; memory strobes are held off while reset is asserted
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        mem_en     = 1'b0;
        mem_addr   = '0;
        instr_ack  = 1'b0;
        instr_data = '0;
        fault      = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_en   = rstz & instr_req & hit;
                mem_addr = rstz ? word_addr : '0;
                if (instr_req) begin
                    if (hit) begin
                        if (WAIT_STATES > 0) begin
                            state_d = WAIT;
                            wait_d  = WAIT_LOAD;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            WAIT: begin
                // A withdrawn request abandons the fetch right away
                if (!instr_req) begin
                    state_d = IDLE;
                    wait_d  = '0;
                end else if (wait_q == 4'd0) begin
                    state_d = DATA;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            DATA: begin
                instr_ack  = instr_req;
                instr_data = instr_req ? mem_rdata : '0;
                state_d    = IDLE;
            end
            ERR: begin
                instr_ack  = instr_req;
                instr_data = INSTR_ILLEGAL;
                fault      = instr_req;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                wait_d  = '0;
            end
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign count_inc     = (state_q == DATA) & instr_req;
    assign fault_capture = (state_q == ERR) & instr_req;

    // Sticky record of the last faulting fetch address
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            fault_addr_q <= '0;
        end else if (fault_capture) begin
            fault_addr_q <= instr_addr;
        end
    end

    // Completed-fetch counter; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            fetch_count_q <= '0;
        end else if (count_inc) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fault_addr  = fault_addr_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_krz_fetch_responder.sv
// tb/tb_krz_fetch_responder.sv - self-checking bench for krz_fetch_responder
module tb_krz_fetch_responder;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] addr  [3];
    logic        req   [3];
    logic [31:0] data  [3];
    logic        ack   [3];
    logic [9:0]  maddr [3];
    logic        men   [3];
    logic [31:0] rdata [3];
    logic        flt   [3];
    logic [31:0] faddr [3];
    logic [31:0] fcnt  [3];

    logic [31:0] mem [1024];
    int          ws  [3] = '{0, 3, 5};
    logic [31:0] exp_count [3];
    logic [31:0] exp_faddr [3];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    krz_fetch_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rstz(rstz), .instr_addr(addr[0]), .instr_req(req[0]),
        .instr_data(data[0]), .instr_ack(ack[0]), .mem_addr(maddr[0]), .mem_en(men[0]),
        .mem_rdata(rdata[0]), .fault(flt[0]), .fault_addr(faddr[0]), .fetch_count(fcnt[0]));
    krz_fetch_responder #(.WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rstz(rstz), .instr_addr(addr[1]), .instr_req(req[1]),
        .instr_data(data[1]), .instr_ack(ack[1]), .mem_addr(maddr[1]), .mem_en(men[1]),
        .mem_rdata(rdata[1]), .fault(flt[1]), .fault_addr(faddr[1]), .fetch_count(fcnt[1]));
    krz_fetch_responder #(.WAIT_STATES(5)) u_dut2 (
        .clk(clk), .rstz(rstz), .instr_addr(addr[2]), .instr_req(req[2]),
        .instr_data(data[2]), .instr_ack(ack[2]), .mem_addr(maddr[2]), .mem_en(men[2]),
        .mem_rdata(rdata[2]), .fault(flt[2]), .fault_addr(faddr[2]), .fetch_count(fcnt[2]));

    // Synchronous boot memories, one read port per responder
    always @(posedge clk) if (men[0]) rdata[0] <= mem[maddr[0]];
    always @(posedge clk) if (men[1]) rdata[1] <= mem[maddr[1]];
    always @(posedge clk) if (men[2]) rdata[2] <= mem[maddr[2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return ((a - 32'h0000_0000) < 32'd4096) && (a % 4 == 0);
    endfunction

    // One full fetch as a core would issue it; returns the absolute ack cycle
    task automatic fetch(input int k, input logic [31:0] a, output int unsigned ack_cyc);
        bit          h;
        int          lat;
        int          c;
        int          mpulse;
        logic [31:0] ed;
        h   = model_hit(a);
        lat = h ? 1 + ws[k] : 1;
        ed  = h ? mem[a / 4] : 32'h0;
        addr[k] = a;
        req[k]  = 1'b1;
        #1;
        chk("idle_quiet", {31'd0, ack[k] | flt[k]}, 32'd0);
        chk("mem_en", {31'd0, men[k]}, {31'd0, h});
        if (h) chk("mem_addr", {22'd0, maddr[k]}, a / 4);
        c = 0;
        mpulse = 0;
        do begin
            @(posedge clk);
            #2;
            c++;
            if (men[k]) mpulse++;
        end while (!ack[k] && !flt[k] && c < 40);
        ack_cyc = cyc;
        chk("latency", 32'(c), 32'(lat));
        chk("ack", {31'd0, ack[k]}, 32'd1);
        chk("data", data[k], ed);
        chk("fault", {31'd0, flt[k]}, {31'd0, !h});
        chk("mem_en_once", 32'(mpulse), 32'd0);
        if (h) exp_count[k] = exp_count[k] + 32'd1;
        else   exp_faddr[k] = a;
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        chk("fault_addr", faddr[k], exp_faddr[k]);
        chk("fetch_count", fcnt[k], exp_count[k]);
    endtask

    initial begin
        int unsigned s;
        int unsigned a0, a1, a2;
        int          k;
        int          r;
        logic [31:0] ra;
        bit          bad;

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0513;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; req[i] = 1'b0; rdata[i] = '0;
            exp_count[i] = '0; exp_faddr[i] = '0;
        end
        rstz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, ack[0]}, 32'd0);
        chk("rst_en", {31'd0, men[0]}, 32'd0);
        chk("rst_cnt", fcnt[1], 32'd0);
        chk("rst_faddr", faddr[2], 32'd0);
        rstz = 1'b1;
        @(posedge clk);
        #1;

        // Single zero-wait fetch of word 0
        fetch(0, 32'h0, a0);
        chk("first_data_count", fcnt[0], 32'd1);

        // Sequential fetches issued back to back
        s = cyc;
        fetch(0, 32'h0, a0);
        fetch(0, 32'h4, a1);
        fetch(0, 32'h8, a2);
        chk("b2b_ack0", a0, s + 1);
        chk("b2b_ack1", a1, s + 3);
        chk("b2b_ack2", a2, s + 5);

        // Out-of-window and misaligned fetches
        fetch(0, 32'h0000_1000, a0);
        chk("oow_faddr", faddr[0], 32'h0000_1000);
        fetch(0, 32'h0000_0002, a0);
        chk("mis_faddr", faddr[0], 32'h0000_0002);
        fetch(0, 32'h0000_0FFC, a0);

        // Wait-state fetch
        fetch(1, 32'h10, a0);

        // Request withdrawn during wait states and during the error cycle
        addr[1] = 32'h20; req[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req[1] = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #2;
            if (ack[1] || flt[1]) bad = 1'b1;
        end
        chk("withdraw_quiet", {31'd0, bad}, 32'd0);
        chk("withdraw_count", fcnt[1], exp_count[1]);
        addr[1] = 32'h3; req[1] = 1'b1;
        @(posedge clk);
        #1;
        req[1] = 1'b0;
        #1;
        chk("withdraw_err", {30'd0, ack[1], flt[1]}, 32'd0);
        @(posedge clk);
        #1;
        chk("withdraw_faddr", faddr[1], exp_faddr[1]);
        fetch(1, 32'h24, a0);

        // Randomised fetches on the first two responders
        for (int n = 0; n < 24; n++) begin
            k = n % 2;
            r = $urandom_range(0, 3);
            if (r <= 1) ra = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            else if (r == 2) ra = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
            else begin
                ra = $urandom;
                if (ra < 32'd4096) ra = ra + 32'd4096;
            end
            fetch(k, ra, a0);
        end

        // Reset while in wait states
        fetch(2, 32'h8, a0);
        addr[2] = 32'h40; req[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstz = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, ack[2]}, 32'd0);
        chk("mid_rst_data", data[2], 32'd0);
        chk("mid_rst_en", {31'd0, men[2]}, 32'd0);
        chk("mid_rst_maddr", {22'd0, maddr[2]}, 32'd0);
        chk("mid_rst_fault", {31'd0, flt[2]}, 32'd0);
        chk("mid_rst_faddr", faddr[0], 32'd0);
        chk("mid_rst_cnt", fcnt[2], 32'd0);
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #2;
            if (ack[2] || flt[2]) bad = 1'b1;
        end
        chk("mid_rst_noack", {31'd0, bad}, 32'd0);
        req[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_count[i] = '0; exp_faddr[i] = '0;
        end
        @(posedge clk);
        #1;
        rstz = 1'b1;
        @(posedge clk);
        #1;
        fetch(2, 32'h40, a0);

        // Counter wrap
        force u_dut0.fetch_count_q = 32'hFFFF_FFFF;
        #1;
        release u_dut0.fetch_count_q;
        #1;
        chk("preload", fcnt[0], 32'hFFFF_FFFF);
        exp_count[0] = 32'hFFFF_FFFF;
        fetch(0, 32'h0, a0);
        chk("wrap", fcnt[0], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
